// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with reserve > flush > clear priority, plus a registered
// population count of the busy vector.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned NWR     = 2,
    parameter int unsigned ZERO_R0 = 1,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic [NWR-1:0]    wr_clr_i,
    input  logic              rsv_en_i,
    input  logic [AW-1:0]     rsv_addr_i,
    input  logic              flush_i,
    output logic [NREG-1:0]   busy_o,
    output logic [AW:0]       busy_cnt_o
);

    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_cnt;
    logic [NREG-1:0] w_busy_d;
    logic [NREG-1:0] w_clr_vec;
    logic [NREG-1:0] w_rsv_vec;
    logic [AW:0]     w_cnt_d;

    always_comb begin
        w_clr_vec = '0;
        w_rsv_vec = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wr_en_i[k] && wr_clr_i[k]) begin
                w_clr_vec[wr_addr_i[k*AW +: AW]] = 1'b1;
            end
        end
        if (rsv_en_i) begin
            w_rsv_vec[rsv_addr_i] = 1'b1;
        end

        w_busy_d = r_busy;
        for (int r = 0; r < NREG; r++) begin
            if (w_rsv_vec[r]) begin
                w_busy_d[r] = 1'b1;
            end else if (flush_i || w_clr_vec[r]) begin
                w_busy_d[r] = 1'b0;
            end
        end
        if (ZERO_R0 != 0) begin
            w_busy_d[0] = 1'b0;
        end

        // Count the post-update vector so busy_cnt_o matches busy bits next cycle.
        w_cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_d = w_cnt_d + {{AW{1'b0}}, w_busy_d[r]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_cnt  <= w_cnt_d;
        end
    end

    assign busy_o     = r_busy;
    assign busy_cnt_o = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hazard scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write->read forwarding of data and busy clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 2,
    parameter int unsigned ZERO_R0 = 1,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic [NWR-1:0]      wr_clr_i,
    input  logic                rsv_en_i,
    input  logic [AW-1:0]       rsv_addr_i,
    input  logic                flush_i,
    output logic [AW:0]         busy_cnt_o
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;

    regfile_scoreboard #(
        .NREG    (NREG),
        .NWR     (NWR),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_clr_i   (wr_clr_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .flush_i    (flush_i),
        .busy_o     (w_busy),
        .busy_cnt_o (busy_cnt_o)
    );

    // Ascending port loop: the last NBA to a shared address (highest port) wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en_i[k] && !((ZERO_R0 != 0) && (wr_addr_i[k*AW +: AW] == '0))) begin
                    r_regs[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] w_hit;
    logic [NRD-1:0] w_hit_clr;
`endif

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
`ifdef REGFILE_BYPASS_EN
        w_hit     = '0;
        w_hit_clr = '0;
`endif
        for (int i = 0; i < NRD; i++) begin
            if ((ZERO_R0 != 0) && (rd_addr_i[i*AW +: AW] == '0)) begin
                rd_data_o[i*XLEN +: XLEN] = '0;
            end else begin
                rd_data_o[i*XLEN +: XLEN] = r_regs[rd_addr_i[i*AW +: AW]];
            end
            rd_busy_o[i] = w_busy[rd_addr_i[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == rd_addr_i[i*AW +: AW]) &&
                    !((ZERO_R0 != 0) && (rd_addr_i[i*AW +: AW] == '0))) begin
                    rd_data_o[i*XLEN +: XLEN] = wr_data_i[k*XLEN +: XLEN];
                    w_hit[i]                  = 1'b1;
                    w_hit_clr[i]              = wr_clr_i[k];
                end
            end
            // A same-cycle reserve of the register re-arms it, so it must still stall.
            if (w_hit[i] && w_hit_clr[i] &&
                !(rsv_en_i && (rsv_addr_i == rd_addr_i[i*AW +: AW]))) begin
                rd_busy_o[i] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, hand sequences and a
// randomized run against a behavioural model.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_clr;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    int          m_cnt;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_clr_i   (wr_clr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush),
        .busy_cnt_o (busy_cnt)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  clr;
        logic        rsv;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t tv [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read data: stored value, overridden by a same-cycle write when bypass exists.
    function automatic logic [31:0] m_rd(input int i);
        logic [4:0]  a;
        logic [31:0] d;
        a = rd_addr[i*5 +: 5];
        if (a == 5'd0) return 32'd0;
        d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wr_addr[k*5 +: 5] == a) d = wr_data[k*32 +: 32];
`endif
        return d;
    endfunction

    function automatic logic m_bsy(input int i);
        logic [4:0] a;
        logic       b;
        logic       hit;
        logic       c;
        a   = rd_addr[i*5 +: 5];
        b   = m_busy[a];
        hit = 1'b0;
        c   = 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wr_addr[k*5 +: 5] == a && a != 5'd0) begin
                hit = 1'b1;
                c   = wr_clr[k];
            end
        if (hit && c && !(rsv_en && rsv_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_step();
        logic [31:0] nb;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
            m_busy = 32'd0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (wr_en[k] && wr_addr[k*5 +: 5] != 5'd0)
                    m_reg[wr_addr[k*5 +: 5]] = wr_data[k*32 +: 32];
            nb = m_busy;
            for (int r = 1; r < 32; r++) begin
                if (rsv_en && rsv_addr == 5'(r)) nb[r] = 1'b1;
                else if (flush) nb[r] = 1'b0;
                else
                    for (int k = 0; k < 2; k++)
                        if (wr_en[k] && wr_clr[k] && wr_addr[k*5 +: 5] == 5'(r)) nb[r] = 1'b0;
            end
            nb[0]  = 1'b0;
            m_busy = nb;
        end
        m_cnt = $countones(m_busy);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst    = 1'b0;
        wr_en  = 2'b00;
        wr_clr = 2'b00;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s rd_data%0d", tag, i), rd_data[i*32 +: 32], m_rd(i));
            chk($sformatf("%s rd_busy%0d", tag, i), {31'd0, rd_busy[i]}, {31'd0, m_bsy(i)});
        end
        chk($sformatf("%s busy_cnt", tag), {26'd0, busy_cnt}, 32'(m_cnt));
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
        m_busy   = 32'd0;
        m_cnt    = 0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_addr = '0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        idle();

        // Fill every register, reserve a few, then reset with a competing write/reserve.
        for (int a = 0; a < 32; a += 2) begin
            wr_en   = 2'b11;
            wr_addr = {5'(a + 1), 5'(a)};
            wr_data = {$urandom() | 32'h1, $urandom() | 32'h1};
            tick();
        end
        idle();
        rsv_en = 1'b1;
        rsv_addr = 5'd5;
        tick();
        rsv_addr = 5'd12;
        tick();
        rst      = 1'b1;
        wr_en    = 2'b01;
        wr_addr  = {5'd0, 5'd3};
        wr_data  = {32'd0, 32'hFFFF_FFFF};
        rsv_addr = 5'd7;
        tick();
        idle();
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            chk($sformatf("reset rd x%0d", a), rd_data[31:0], 32'd0);
            chk($sformatf("reset rd x%0d", a + 1), rd_data[63:32], 32'd0);
            chk($sformatf("reset busy x%0d/x%0d", a, a + 1), {30'd0, rd_busy}, 32'd0);
        end
        chk("reset busy_cnt", {26'd0, busy_cnt}, 32'd0);

        //         rst   we     wa0    wd0            wa1    wd1     clr   rsv   ra    fl    rd0   rd1   e0             e1             eb     ec
        tv[0]  = '{1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  2'b00, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
        tv[1]  = '{1'b0, 2'b11, 5'd0, 32'h12345678, 5'd3, 32'h33, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 32'h0,        32'h33,        2'b00, 6'd0};
        tv[2]  = '{1'b0, 2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 2'b00, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 2'b00, 6'd0};
        tv[3]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b1, 5'd3, 1'b0, 5'd3, 5'd5, 32'h33,       32'hDEADBEEF, 2'b01, 6'd1};
        tv[4]  = '{1'b0, 2'b01, 5'd3, 32'h44,       5'd0, 32'h0,  2'b01, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h44,       32'h22,        2'b00, 6'd0};
        tv[5]  = '{1'b0, 2'b10, 5'd0, 32'h0,        5'd3, 32'h55, 2'b10, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'h55,       32'h55,        2'b11, 6'd1};
        tv[6]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b1, 5'd1, 1'b0, 5'd1, 5'd3, 32'h0,        32'h55,        2'b11, 6'd2};
        tv[7]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b1, 5'd2, 1'b0, 5'd2, 5'd4, 32'h0,        32'h0,         2'b01, 6'd3};
        tv[8]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b1, 5'd4, 1'b0, 5'd4, 5'd3, 32'h0,        32'h55,        2'b11, 6'd4};
        tv[9]  = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b1, 5'd9, 1'b1, 5'd9, 5'd1, 32'h0,        32'h0,         2'b01, 6'd1};
        tv[10] = '{1'b0, 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 5'd9, 32'h0,        32'h0,         2'b10, 6'd1};
        tv[11] = '{1'b0, 2'b01, 5'd9, 32'h99,       5'd0, 32'h0,  2'b00, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h99,       32'h99,        2'b11, 6'd1};
        tv[12] = '{1'b0, 2'b11, 5'd9, 32'hBB,       5'd9, 32'hAA, 2'b10, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 32'hAA,       32'h0,         2'b00, 6'd0};
        tv[13] = '{1'b1, 2'b01, 5'd5, 32'h1,        5'd0, 32'h0,  2'b00, 1'b1, 5'd6, 1'b0, 5'd5, 5'd7, 32'h0,        32'h0,         2'b00, 6'd0};

        for (int n = 0; n < 14; n++) begin
            rst      = tv[n].rst;
            wr_en    = tv[n].we;
            wr_addr  = {tv[n].wa1, tv[n].wa0};
            wr_data  = {tv[n].wd1, tv[n].wd0};
            wr_clr   = tv[n].clr;
            rsv_en   = tv[n].rsv;
            rsv_addr = tv[n].ra;
            flush    = tv[n].fl;
            rd_addr  = {tv[n].rd1, tv[n].rd0};
            tick();
            idle();
            #1;
            chk($sformatf("vec%0d rd_data0", n), rd_data[31:0], tv[n].e0);
            chk($sformatf("vec%0d rd_data1", n), rd_data[63:32], tv[n].e1);
            chk($sformatf("vec%0d rd_busy", n), {30'd0, rd_busy}, {30'd0, tv[n].eb});
            chk($sformatf("vec%0d busy_cnt", n), {26'd0, busy_cnt}, {26'd0, tv[n].ec});
        end

        // Same-cycle write with clear while reading a reserved register.
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd6};
        wr_data = {32'd0, 32'h0000_0600};
        tick();
        idle();
        rsv_en   = 1'b1;
        rsv_addr = 5'd6;
        tick();
        idle();
        wr_en   = 2'b01;
        wr_clr  = 2'b01;
        wr_data = {32'd0, 32'hA5A5_A5A5};
        rd_addr = {5'd6, 5'd6};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass rd_data", rd_data[31:0], 32'hA5A5_A5A5);
        chk("bypass rd_busy", {31'd0, rd_busy[0]}, 32'd0);
`else
        chk("no-bypass rd_data", rd_data[31:0], 32'h0000_0600);
        chk("no-bypass rd_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
        // A same-cycle reserve must keep the forwarded read stalled.
        rsv_en   = 1'b1;
        rsv_addr = 5'd6;
        #1;
        chk("bypass+rsv rd_busy", {31'd0, rd_busy[1]}, 32'd1);
        rsv_en = 1'b0;
        tick();
        idle();
        #1;
        chk("after write rd_data", rd_data[31:0], 32'hA5A5_A5A5);
        chk("after write rd_busy", {31'd0, rd_busy[0]}, 32'd0);
        chk("after write busy_cnt", {26'd0, busy_cnt}, 32'd0);

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wr_en    = 2'($urandom_range(0, 3));
            wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data  = {$urandom(), $urandom()};
            wr_clr   = 2'($urandom_range(0, 3));
            rsv_en   = ($urandom_range(0, 9) < 4);
            rsv_addr = 5'($urandom_range(0, 9));
            flush    = ($urandom_range(0, 19) == 0);
            rd_addr  = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
            chk_model($sformatf("rand%0d", c));
            tick();
        end
        idle();
        chk_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
